// File: rtl/byte_serial_adder_ctrl_pkg.sv
// Shared encodings for the byte-serial adder sequencer.
// Front ends size their operand registers from DEFAULT_BYTES.
package byte_serial_adder_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_BYTES = 4;

endpackage

// File: rtl/byte_serial_adder_ctrl_adder8.sv
// Single 8-bit carry-chain adder, time-shared by the controller across all operand bytes.
module adder8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       carry_in,
    output logic [7:0] sum,
    output logic       carry_out
);

    assign {carry_out, sum} = {1'b0, a} + {1'b0, b} + {8'd0, carry_in};

endmodule

// File: rtl/byte_serial_adder_ctrl.sv
// Multi-byte add/subtract sequencer: walks one byte per clock, LSB first, through adder8,
// chaining carry in a register and reporting carry-out and signed overflow.
module byte_serial_adder_ctrl
    import byte_serial_adder_ctrl_pkg::*;
#(
    parameter int BYTES = DEFAULT_BYTES
) (
    input  logic               iClk,
    input  logic               iRst_n,
    input  logic               iStart,
    input  logic [8*BYTES-1:0] iOp_a,
    input  logic [8*BYTES-1:0] iOp_b,
    input  logic               iC,
    input  logic               iSub,
    output logic               oBusy,
    output logic               oDone,
    output logic [8*BYTES-1:0] oResult,
    output logic               oData_C,
    output logic               oOverflow
);

    localparam int W     = 8 * BYTES;
    localparam int IDX_W = $clog2(BYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);

    state_t             state;
    state_t             next_state;
    logic [W-1:0]       a_reg;
    logic [W-1:0]       b_reg;
    logic               carry_reg;
    logic [IDX_W-1:0]   idx;
    logic [IDX_W+2:0]   bit_base;
    logic [W-1:0]       result_reg;
    logic               data_c_reg;
    logic               overflow_reg;
    logic [7:0]         a_byte;
    logic [7:0]         b_byte;
    logic [7:0]         sum_byte;
    logic               carry_out;

    // b_reg already holds the inverted subtrahend, so the adder only ever adds.
    assign bit_base = {idx, 3'b000};
    assign a_byte   = a_reg[bit_base +: 8];
    assign b_byte   = b_reg[bit_base +: 8];

    adder8 u_adder8 (
        .a         (a_byte),
        .b         (b_byte),
        .carry_in  (carry_reg),
        .sum       (sum_byte),
        .carry_out (carry_out)
    );

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (iStart) next_state = RUN;
            RUN:     if (idx == LAST_IDX) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // idx saturates at the last byte; the FSM leaves RUN on that same edge.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            a_reg        <= '0;
            b_reg        <= '0;
            carry_reg    <= 1'b0;
            idx          <= '0;
            result_reg   <= '0;
            data_c_reg   <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (iStart) begin
                        a_reg        <= iOp_a;
                        b_reg        <= iSub ? ~iOp_b : iOp_b;
                        carry_reg    <= iSub | iC;
                        idx          <= '0;
                        result_reg   <= '0;
                        data_c_reg   <= 1'b0;
                        overflow_reg <= 1'b0;
                    end
                end
                RUN: begin
                    result_reg[bit_base +: 8] <= sum_byte;
                    carry_reg                 <= carry_out;
                    if (idx == LAST_IDX) begin
                        data_c_reg   <= carry_out;
                        overflow_reg <= (a_reg[W-1] == b_reg[W-1]) && (sum_byte[7] != a_reg[W-1]);
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign oBusy     = (state != IDLE);
    assign oDone     = (state == DONE);
    assign oResult   = result_reg;
    assign oData_C   = data_c_reg;
    assign oOverflow = overflow_reg;

endmodule

// File: tb/tb_byte_serial_adder_ctrl.sv
// Directed scoreboard bench for byte_serial_adder_ctrl: a BYTES=4 instance for the
// arithmetic/timing/reset cases and a BYTES=2 instance for back-to-back throughput.
module tb_byte_serial_adder_ctrl;

    typedef struct packed {
        logic [31:0] r;
        logic        c;
        logic        ov;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start4, c4, sub4, busy4, done4, dc4, ov4;
    logic [31:0] a4, b4, res4;
    logic        start2, c2, sub2, busy2, done2, dc2, ov2;
    logic [15:0] a2, b2, res2;

    exp_t q4[$];
    exp_t q2[$];
    int   checks = 0;
    int   errors = 0;

    byte_serial_adder_ctrl #(.BYTES(4)) dut4 (
        .iClk(clk), .iRst_n(rst_n), .iStart(start4), .iOp_a(a4), .iOp_b(b4),
        .iC(c4), .iSub(sub4), .oBusy(busy4), .oDone(done4), .oResult(res4),
        .oData_C(dc4), .oOverflow(ov4)
    );

    byte_serial_adder_ctrl #(.BYTES(2)) dut2 (
        .iClk(clk), .iRst_n(rst_n), .iStart(start2), .iOp_a(a2), .iOp_b(b2),
        .iC(c2), .iSub(sub2), .oBusy(busy2), .oDone(done2), .oResult(res2),
        .oData_C(dc2), .oOverflow(ov2)
    );

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Drives one request into the 4-byte instance and returns just after the accepting edge.
    task automatic apply_stimulus(input logic [31:0] a, input logic [31:0] b, input logic cin,
                                  input logic sub, input exp_t e);
        a4 = a; b4 = b; c4 = cin; sub4 = sub; start4 = 1'b1;
        q4.push_back(e);
        @(posedge clk); #1;
        start4 = 1'b0;
        a4 = $urandom; b4 = $urandom; c4 = ~cin; sub4 = ~sub;
        check("busy_after_accept", {63'd0, busy4}, 64'd1);
        check("done_after_accept", {63'd0, done4}, 64'd0);
    endtask

    // Waits (bounded) for done, compares against the scoreboard, then checks pulse width and hold.
    task automatic check_output(input string tag, input bit poke);
        int   n;
        exp_t e;
        n = 0;
        while (done4 !== 1'b1 && n < 12) begin
            if (poke && n == 1) begin
                start4 = 1'b1; a4 = 32'hDEADBEEF; b4 = 32'h01010101;
            end else begin
                start4 = 1'b0;
            end
            @(posedge clk); #1;
            n++;
        end
        start4 = 1'b0;
        // done is visible in the cycle after the 4th RUN edge
        check({tag, "_latency"}, 64'(n), 64'd4);
        if (q4.size() == 0) begin
            check({tag, "_scoreboard_empty"}, 64'd0, 64'd1);
        end else begin
            e = q4.pop_front();
            check({tag, "_result"}, {32'd0, res4}, {32'd0, e.r});
            check({tag, "_carry"}, {63'd0, dc4}, {63'd0, e.c});
            check({tag, "_overflow"}, {63'd0, ov4}, {63'd0, e.ov});
            @(posedge clk); #1;
            check({tag, "_done_width"}, {63'd0, done4}, 64'd0);
            check({tag, "_busy_fall"}, {63'd0, busy4}, 64'd0);
            check({tag, "_result_hold"}, {32'd0, res4}, {32'd0, e.r});
        end
    endtask

    initial begin
        int   pulses;
        int   last_cycle;
        exp_t e;

        rst_n = 1'b0;
        start4 = 1'b0; a4 = '0; b4 = '0; c4 = 1'b0; sub4 = 1'b0;
        start2 = 1'b0; a2 = '0; b2 = '0; c2 = 1'b0; sub2 = 1'b0;
        #12;
        check("reset_busy4", {63'd0, busy4}, 64'd0);
        check("reset_done4", {63'd0, done4}, 64'd0);
        check("reset_result4", {32'd0, res4}, 64'd0);
        check("reset_flags4", {62'd0, dc4, ov4}, 64'd0);
        check("reset_busy2", {63'd0, busy2}, 64'd0);
        check("reset_result2", {48'd0, res2}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_after_reset", {63'd0, busy4}, 64'd0);

        apply_stimulus(32'h000000FF, 32'h00000001, 1'b0, 1'b0, '{32'h00000100, 1'b0, 1'b0});
        check_output("add_ff_1", 1'b0);

        apply_stimulus(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, '{32'h00000000, 1'b1, 1'b0});
        check_output("add_wrap", 1'b0);

        apply_stimulus(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, '{32'h80000000, 1'b0, 1'b1});
        check_output("add_ovf", 1'b0);

        apply_stimulus(32'h00000005, 32'h00000007, 1'b0, 1'b1, '{32'hFFFFFFFE, 1'b0, 1'b0});
        check_output("sub_5_7", 1'b0);

        apply_stimulus(32'h80000000, 32'h00000001, 1'b1, 1'b1, '{32'h7FFFFFFF, 1'b1, 1'b1});
        check_output("sub_ovf", 1'b0);

        apply_stimulus(32'h12345678, 32'h11111111, 1'b1, 1'b0, '{32'h2345678A, 1'b0, 1'b0});
        check_output("cin_poke", 1'b1);
        @(posedge clk); #1;
        check("poke_not_queued", {63'd0, busy4}, 64'd0);

        // Abort a run after two RUN edges; the partial low bytes must vanish at once.
        apply_stimulus(32'h12345678, 32'h11111111, 1'b1, 1'b0, '{32'h2345678A, 1'b0, 1'b0});
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("midrun_busy", {63'd0, busy4}, 64'd0);
        check("midrun_done", {63'd0, done4}, 64'd0);
        check("midrun_result", {32'd0, res4}, 64'd0);
        check("midrun_flags", {62'd0, dc4, ov4}, 64'd0);
        q4.delete();
        #2;
        rst_n = 1'b1;
        apply_stimulus(32'h00010000, 32'h0000FFFF, 1'b0, 1'b0, '{32'h0001FFFF, 1'b0, 1'b0});
        check_output("after_reset", 1'b0);

        // Held start on the 2-byte instance: pulses every BYTES+2 cycles.
        for (int k = 0; k < 3; k++) q2.push_back('{32'h0000FFFE, 1'b1, 1'b0});
        a2 = 16'hFFFF; b2 = 16'hFFFF; c2 = 1'b0; sub2 = 1'b0; start2 = 1'b1;
        pulses = 0;
        last_cycle = -1;
        for (int cyc = 0; cyc < 30 && pulses < 3; cyc++) begin
            @(posedge clk); #1;
            if (done2 === 1'b1) begin
                if (last_cycle >= 0) check("held_gap", 64'(cyc - last_cycle), 64'd4);
                last_cycle = cyc;
                pulses++;
                if (q2.size() != 0) begin
                    e = q2.pop_front();
                    check("held_result", {48'd0, res2}, {32'd0, e.r});
                    check("held_carry", {63'd0, dc2}, {63'd0, e.c});
                    check("held_overflow", {63'd0, ov2}, {63'd0, e.ov});
                end
            end
        end
        start2 = 1'b0;
        check("held_pulse_count", 64'(pulses), 64'd3);
        repeat (6) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
